// File: rtl/alt_vipitc131_common_sync_filtered_pkg.sv
// Shared helpers for the filtered input synchroniser: parameter legality
// checks and the persistence-counter width.
package alt_vipitc131_common_sync_filtered_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_MAX      = 255;

    function automatic bit stages_legal(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

    function automatic bit filter_legal(input int filter_cycles);
        return (filter_cycles >= 0) && (filter_cycles <= FILTER_MAX);
    endfunction

    // Counter must hold FILTER_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int filter_cycles);
        return (filter_cycles < 2) ? 1 : $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/alt_vipitc131_common_sync_filter_chan.sv
// One channel: persistence filter on the synchronised level plus the
// registered rise/fall pulses that accompany each accepted change.
module alt_vipitc131_common_sync_filter_chan
    import alt_vipitc131_common_sync_filtered_pkg::*;
#(
    parameter int FILTER_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic change_d_o
);

    logic level_q, level_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic load;

    if (FILTER_CYCLES == 0) begin : g_nofilt
        assign load = sync_i ^ level_q;
    end else begin : g_filt
        localparam int CW = cnt_width(FILTER_CYCLES);
        localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          hit;

        // Load happens exactly at LAST, so the counter never wraps.
        always_comb begin
            cnt_d = cnt_q + CW'(1);
            hit   = 1'b0;
            if (sync_i == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                hit   = 1'b1;
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign load = hit;
    end

    always_comb begin
        level_d = load ? sync_i : level_q;
        rise_d  = load & sync_i;
        fall_d  = load & ~sync_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign change_d_o = rise_d | fall_d;

endmodule

// File: rtl/alt_vipitc131_common_sync_filtered.sv
// Multi-channel synchroniser into sync_clock with per-channel glitch filter,
// edge pulses and a combined change flag.
module alt_vipitc131_common_sync_filtered
    import alt_vipitc131_common_sync_filtered_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int STAGES          = 2,
    parameter int FILTER_CYCLES   = 0,
    parameter int CLOCKS_ARE_SAME = 0
) (
    input  logic             sync_clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("alt_vipitc131_common_sync_filtered: STAGES must be 2..4");
    end
    if (!filter_legal(FILTER_CYCLES)) begin : g_bad_filter
        $error("alt_vipitc131_common_sync_filtered: FILTER_CYCLES must be 0..255");
    end

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] change_d;
    logic             any_change_q, any_change_d;

    if (CLOCKS_ARE_SAME != 0) begin : g_same
        logic [WIDTH-1:0] same_q;

        always_ff @(posedge sync_clock) begin
            if (rst) begin
                same_q <= '0;
            end else begin
                same_q <= data_in;
            end
        end

        assign sync_s = same_q;
    end else begin : g_sync
        // Only the first stage is the asynchronous capture point, so only it gets the false path.
        (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name SDC_STATEMENT {set_false_path -to [get_keepers {*alt_vipitc131_common_sync_filtered*meta_q*}]}" *)
        logic [WIDTH-1:0] meta_q;
        (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
        logic [WIDTH-1:0] chain_q [STAGES-1];

        always_ff @(posedge sync_clock) begin
            if (rst) begin
                meta_q <= '0;
                for (int k = 0; k < STAGES - 1; k++) begin
                    chain_q[k] <= '0;
                end
            end else begin
                meta_q     <= data_in;
                chain_q[0] <= meta_q;
                for (int k = 1; k < STAGES - 1; k++) begin
                    chain_q[k] <= chain_q[k-1];
                end
            end
        end

        assign sync_s = chain_q[STAGES-2];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        alt_vipitc131_common_sync_filter_chan #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_chan (
            .clk_i      (sync_clock),
            .rst_i      (rst),
            .sync_i     (sync_s[i]),
            .level_o    (data_out[i]),
            .rise_o     (rise_pulse[i]),
            .fall_o     (fall_pulse[i]),
            .change_d_o (change_d[i])
        );
    end

    // Built from the pulses' next values so it lands in the same cycle as them.
    assign any_change_d = |change_d;

    always_ff @(posedge sync_clock) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_alt_vipitc131_common_sync_filtered.sv
// Bench for the filtered synchroniser: several configurations, a reference
// model feeding an expected queue, and scenario tasks with inline checks.
module tb_alt_vipitc131_common_sync_filtered;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // u1: W1 S2 F0 | u2: W1 S2 F4 | u3: W8 S2 F0 | u4: W1 S3 F10
    // u5: W1 S4 F0 same-clock | u6: W2 S2 F1 | u7: W4 S3 F3
    logic       din1 = 1'b0, o1, r1, f1, a1;
    logic       din2 = 1'b0, o2, r2, f2, a2;
    logic [7:0] din3 = 8'h00, o3, r3, f3;
    logic       a3;
    logic       din4 = 1'b0, o4, r4, f4, a4;
    logic       din5 = 1'b0, o5, r5, f5, a5;
    logic [1:0] din6 = 2'b00, o6, r6, f6;
    logic       a6;
    logic [3:0] din7 = 4'h0, o7, r7, f7;
    logic       a7;

    alt_vipitc131_common_sync_filtered #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(0), .CLOCKS_ARE_SAME(0)) u1 (
        .sync_clock(clk), .rst(rst), .data_in(din1), .data_out(o1),
        .rise_pulse(r1), .fall_pulse(f1), .any_change(a1));
    alt_vipitc131_common_sync_filtered #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(4), .CLOCKS_ARE_SAME(0)) u2 (
        .sync_clock(clk), .rst(rst), .data_in(din2), .data_out(o2),
        .rise_pulse(r2), .fall_pulse(f2), .any_change(a2));
    alt_vipitc131_common_sync_filtered #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(0), .CLOCKS_ARE_SAME(0)) u3 (
        .sync_clock(clk), .rst(rst), .data_in(din3), .data_out(o3),
        .rise_pulse(r3), .fall_pulse(f3), .any_change(a3));
    alt_vipitc131_common_sync_filtered #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(10), .CLOCKS_ARE_SAME(0)) u4 (
        .sync_clock(clk), .rst(rst), .data_in(din4), .data_out(o4),
        .rise_pulse(r4), .fall_pulse(f4), .any_change(a4));
    alt_vipitc131_common_sync_filtered #(.WIDTH(1), .STAGES(4), .FILTER_CYCLES(0), .CLOCKS_ARE_SAME(1)) u5 (
        .sync_clock(clk), .rst(rst), .data_in(din5), .data_out(o5),
        .rise_pulse(r5), .fall_pulse(f5), .any_change(a5));
    alt_vipitc131_common_sync_filtered #(.WIDTH(2), .STAGES(2), .FILTER_CYCLES(1), .CLOCKS_ARE_SAME(0)) u6 (
        .sync_clock(clk), .rst(rst), .data_in(din6), .data_out(o6),
        .rise_pulse(r6), .fall_pulse(f6), .any_change(a6));
    alt_vipitc131_common_sync_filtered #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(3), .CLOCKS_ARE_SAME(0)) u7 (
        .sync_clock(clk), .rst(rst), .data_in(din7), .data_out(o7),
        .rise_pulse(r7), .fall_pulse(f7), .any_change(a7));

    int checks = 0;
    int errors = 0;

    // Expected word layout: [7:0] data_out, [15:8] rise, [23:16] fall, [24] any_change.
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    int cur = 1;
    int p_d = 2, p_n = 0, p_w = 1;
    logic [7:0] m_dl [4];
    logic [7:0] m_out;
    int         m_run [8];

    task automatic select(input int id);
        cur = id;
        case (id)
            1: begin p_d = 2; p_n = 0;  p_w = 1; end
            2: begin p_d = 2; p_n = 4;  p_w = 1; end
            3: begin p_d = 2; p_n = 0;  p_w = 8; end
            4: begin p_d = 3; p_n = 10; p_w = 1; end
            5: begin p_d = 1; p_n = 0;  p_w = 1; end
            6: begin p_d = 2; p_n = 1;  p_w = 2; end
            default: begin p_d = 3; p_n = 3; p_w = 4; end
        endcase
    endtask

    function automatic logic [31:0] dut_word();
        logic [31:0] w;
        w = '0;
        case (cur)
            1: begin w[7:0] = {7'b0, o1}; w[15:8] = {7'b0, r1}; w[23:16] = {7'b0, f1}; w[24] = a1; end
            2: begin w[7:0] = {7'b0, o2}; w[15:8] = {7'b0, r2}; w[23:16] = {7'b0, f2}; w[24] = a2; end
            3: begin w[7:0] = o3;         w[15:8] = r3;         w[23:16] = f3;         w[24] = a3; end
            4: begin w[7:0] = {7'b0, o4}; w[15:8] = {7'b0, r4}; w[23:16] = {7'b0, f4}; w[24] = a4; end
            5: begin w[7:0] = {7'b0, o5}; w[15:8] = {7'b0, r5}; w[23:16] = {7'b0, f5}; w[24] = a5; end
            6: begin w[7:0] = {6'b0, o6}; w[15:8] = {6'b0, r6}; w[23:16] = {6'b0, f6}; w[24] = a6; end
            default: begin w[7:0] = {4'b0, o7}; w[15:8] = {4'b0, r7}; w[23:16] = {4'b0, f7}; w[24] = a7; end
        endcase
        return w;
    endfunction

    // Reference: input delayed p_d edges, then a new value is accepted once it
    // has disagreed with the output on p_n consecutive edges (every edge if 0).
    task automatic model_edge(input logic r, input logic [7:0] x);
        logic [7:0] s, ri, fa;
        int need;
        ri = '0;
        fa = '0;
        need = (p_n == 0) ? 1 : p_n;
        if (r) begin
            for (int k = 0; k < 4; k++) m_dl[k] = '0;
            m_out = '0;
            for (int c = 0; c < 8; c++) m_run[c] = 0;
        end else begin
            s = m_dl[p_d-1];
            for (int c = 0; c < p_w; c++) begin
                if (s[c] !== m_out[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= need) begin
                        m_out[c] = s[c];
                        if (s[c]) ri[c] = 1'b1;
                        else      fa[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            for (int k = 3; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = x;
        end
        exp_q.push_back({7'b0, |(ri | fa), fa, ri, m_out});
    endtask

    task automatic tick(input logic r, input logic [7:0] x);
        rst = r;
        case (cur)
            1: din1 = x[0];
            2: din2 = x[0];
            3: din3 = x;
            4: din4 = x[0];
            5: din5 = x[0];
            6: din6 = x[1:0];
            default: din7 = x[3:0];
        endcase
        @(posedge clk);
        model_edge(r, x);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 8'h00);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        int nrise, first;
        select(1);
        nrise = 0;
        first = -1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'h01);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_hold i=%0d got=%h exp=%h", i, got, exp); end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h01);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_release i=%0d got=%h exp=%h", i, got, exp); end
            if (r1 === 1'b1) begin nrise++; if (first < 0) first = i; end
        end
        checks++;
        if (nrise != 1 || first != 2) begin
            errors++; $display("FAIL reset_single_rise got count=%0d at=%0d exp count=1 at=2", nrise, first);
        end
    endtask

    task automatic test_basic_latency();
        int first;
        select(1);
        do_reset(2);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_idle i=%0d got=%h exp=%h", i, got, exp); end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'h01);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_step i=%0d got=%h exp=%h", i, got, exp); end
            if (o1 === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", first); end
    endtask

    task automatic test_glitch();
        int nr, nf, nhigh;
        select(2);
        do_reset(2);
        nr = 0; nf = 0; nhigh = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, (i >= 3 && i < 6) ? 8'h01 : 8'h00);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL glitch_short i=%0d got=%h exp=%h", i, got, exp); end
            nr += int'(r2); nf += int'(f2); nhigh += int'(o2);
        end
        checks++;
        if (nr != 0 || nf != 0 || nhigh != 0) begin
            errors++; $display("FAIL glitch_reject got r=%0d f=%0d high=%0d exp 0 0 0", nr, nf, nhigh);
        end
        nr = 0; nf = 0; nhigh = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, (i < 4) ? 8'h01 : 8'h00);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL glitch_pass i=%0d got=%h exp=%h", i, got, exp); end
            nr += int'(r2); nf += int'(f2); nhigh += int'(o2);
        end
        checks++;
        if (nr != 1 || nf != 1 || nhigh != 4) begin
            errors++; $display("FAIL glitch_pass_count got r=%0d f=%0d high=%0d exp 1 1 4", nr, nf, nhigh);
        end
    endtask

    task automatic test_multi_channel();
        int nany;
        select(3);
        do_reset(2);
        nany = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, (i < 2) ? 8'h21 : 8'h29);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL multi i=%0d got=%h exp=%h", i, got, exp); end
            nany += int'(a3);
            if (i == 2 || i == 4) begin
                checks++;
                if (r3 !== ((i == 2) ? 8'h21 : 8'h08) || a3 !== 1'b1) begin
                    errors++; $display("FAIL multi_pulse i=%0d got rise=%h any=%b", i, r3, a3);
                end
            end
        end
        checks++;
        if (nany != 2) begin errors++; $display("FAIL multi_any_count got=%0d exp=2", nany); end
    endtask

    task automatic test_reset_mid_count();
        int nrise, first;
        select(4);
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h01);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL midcount_pre i=%0d got=%h exp=%h", i, got, exp); end
        end
        tick(1'b1, 8'h01);
        got = dut_word(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL midcount_rst got=%h exp=%h", got, exp); end
        nrise = 0;
        first = -1;
        for (int i = 1; i <= 18; i++) begin
            tick(1'b0, 8'h01);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL midcount_post i=%0d got=%h exp=%h", i, got, exp); end
            if (r4 === 1'b1) begin nrise++; if (first < 0) first = i; end
        end
        checks++;
        if (nrise != 1 || first != 13) begin
            errors++; $display("FAIL midcount_rise got count=%0d at=%0d exp count=1 at=13", nrise, first);
        end
    endtask

    task automatic test_same_clock();
        int first;
        select(5);
        do_reset(2);
        first = -1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, (i < 4) ? 8'h01 : 8'h00);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL same_clk i=%0d got=%h exp=%h", i, got, exp); end
            if (o5 === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 1) begin errors++; $display("FAIL same_clk_latency got=%0d exp=1", first); end
    endtask

    task automatic test_toggle();
        select(6);
        do_reset(2);
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, i[0] ? 8'h01 : 8'h02);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL toggle i=%0d got=%h exp=%h", i, got, exp); end
            checks++;
            if ((r6 & f6) !== 2'b00) begin errors++; $display("FAIL toggle_both i=%0d rise=%b fall=%b", i, r6, f6); end
        end
    endtask

    task automatic test_random();
        logic [7:0] x;
        int hold;
        select(7);
        do_reset(2);
        x = 8'h00;
        hold = 0;
        for (int i = 0; i < 200; i++) begin
            if (hold == 0) begin
                x = 8'($urandom_range(0, 15));
                hold = $urandom_range(1, 6);
            end
            hold--;
            tick(1'b0, x);
            got = dut_word(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic_latency();
        test_glitch();
        test_multi_channel();
        test_reset_mid_count();
        test_same_clock();
        test_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
